// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, bit positions and shifter state encoding for the MMIO UART transmitter.
package mmio_uart_tx_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_CTRL    = 2'd2;
   localparam logic [1:0] OFF_BAUDDIV = 2'd3;

   localparam int STAT_FULL  = 0;
   localparam int STAT_EMPTY = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                               input logic empty, input logic full);
      status_word             = '0;
      status_word[STAT_FULL]  = full;
      status_word[STAT_EMPTY] = empty;
      status_word[STAT_BUSY]  = busy;
      status_word[STAT_OVF]   = ovf;
   endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output; pushes when full and pops when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset: only pointers and count define the FIFO's state.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: register file with one-cycle ready handshake, TX FIFO and 8N1 bit shifter.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mmio_req,
   input  logic        mmio_we,
   input  logic [31:0] mmio_addr,
   input  logic [31:0] mmio_wdata,
   output logic [31:0] mmio_rdata,
   output logic        mmio_ready,
   output logic        uart_txd,
   output logic        uart_irq
);

   // Handshake: an access is taken on any edge where req is high and ready is low;
   // ready pulses for exactly one cycle afterwards, carrying read data for reads.
   logic        accept;
   logic        wr;
   logic        rd;
   logic [1:0]  offset;
   logic        push_req;
   logic [31:0] read_word;
   logic        unused_bits;

   logic [1:0]  ctrl;
   logic [15:0] bauddiv;
   logic        overflow;

   logic        fifo_pop;
   logic [7:0]  fifo_rdata;
   logic        fifo_full;
   logic        fifo_empty;

   tx_state_t   state, state_next;
   logic [15:0] baud_cnt, baud_cnt_next;
   logic [2:0]  bit_idx, bit_idx_next;
   logic [7:0]  shreg, shreg_next;
   logic        txd_next;
   logic        busy;
   logic        tick;
   logic        can_start;

   assign offset      = mmio_addr[3:2];
   assign accept      = mmio_req & ~mmio_ready;
   assign wr          = accept & mmio_we;
   assign rd          = accept & ~mmio_we;
   assign push_req    = wr & (offset == OFF_TXDATA);
   assign busy        = (state != TX_IDLE);
   assign unused_bits = ^{mmio_addr[31:4], mmio_addr[1:0], mmio_wdata[31:16]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .wdata (mmio_wdata[7:0]),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      read_word = '0;
      case (offset)
         OFF_STATUS:  read_word = status_word(overflow, busy, fifo_empty, fifo_full);
         OFF_CTRL:    read_word = {30'b0, ctrl};
         OFF_BAUDDIV: read_word = {16'b0, bauddiv};
         default:     read_word = '0;
      endcase
   end

   // Overflow uses the pre-pop full flag, so a push into a full FIFO is dropped even if a pop coincides.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmio_ready <= 1'b0;
         mmio_rdata <= '0;
         ctrl       <= '0;
         bauddiv    <= DEFAULT_DIV;
         overflow   <= 1'b0;
         uart_irq   <= 1'b0;
      end else begin
         mmio_ready <= accept;
         mmio_rdata <= rd ? read_word : '0;
         if (wr && offset == OFF_CTRL)    ctrl    <= mmio_wdata[1:0];
         if (wr && offset == OFF_BAUDDIV) bauddiv <= mmio_wdata[15:0];
         if (push_req && fifo_full)
            overflow <= 1'b1;
         else if (wr && offset == OFF_STATUS && mmio_wdata[STAT_OVF])
            overflow <= 1'b0;
         uart_irq <= ctrl[CTRL_IRQ_EN] & fifo_empty & ~busy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_txd <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_cnt_next;
         bit_idx  <= bit_idx_next;
         shreg    <= shreg_next;
         uart_txd <= txd_next;
      end
   end

   assign tick      = (baud_cnt == '0);
   assign can_start = ctrl[CTRL_EN] & ~fifo_empty;

   // uart_txd is registered, so each branch sets the level of the bit that begins at this edge.
   // The counter reloads from the live BAUDDIV at every bit boundary.
   always_comb begin
      state_next    = state;
      baud_cnt_next = baud_cnt;
      bit_idx_next  = bit_idx;
      shreg_next    = shreg;
      txd_next      = uart_txd;
      fifo_pop      = 1'b0;
      if (state != TX_IDLE && !tick) baud_cnt_next = baud_cnt - 16'd1;
      case (state)
         TX_IDLE: begin
            if (can_start) begin
               fifo_pop      = 1'b1;
               state_next    = TX_START;
               baud_cnt_next = bauddiv;
               shreg_next    = fifo_rdata;
               txd_next      = 1'b0;
            end
         end
         TX_START: begin
            if (tick) begin
               state_next    = TX_DATA;
               baud_cnt_next = bauddiv;
               bit_idx_next  = 3'd0;
               txd_next      = shreg[0];
               shreg_next    = shreg >> 1;
            end
         end
         TX_DATA: begin
            if (tick) begin
               baud_cnt_next = bauddiv;
               if (bit_idx == 3'd7) begin
                  state_next = TX_STOP;
                  txd_next   = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  txd_next     = shreg[0];
                  shreg_next   = shreg >> 1;
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               baud_cnt_next = bauddiv;
               if (can_start) begin
                  fifo_pop   = 1'b1;
                  state_next = TX_START;
                  shreg_next = fifo_rdata;
                  txd_next   = 1'b0;
               end else begin
                  state_next = TX_IDLE;
               end
            end
         end
         default: state_next = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, frame waveform model, corner sequences.
module tb_mmio_uart_tx;

   localparam logic [31:0] A_TXDATA  = 32'h0;
   localparam logic [31:0] A_STATUS  = 32'h4;
   localparam logic [31:0] A_CTRL    = 32'h8;
   localparam logic [31:0] A_BAUDDIV = 32'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mmio_req = 1'b0;
   logic        mmio_we = 1'b0;
   logic [31:0] mmio_addr = '0;
   logic [31:0] mmio_wdata = '0;
   logic [31:0] mmio_rdata;
   logic        mmio_ready;
   logic        uart_txd;
   logic        uart_irq;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .FIFO_DEPTH  (4),
      .DEFAULT_DIV (16'd433)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mmio_req   (mmio_req),
      .mmio_we    (mmio_we),
      .mmio_addr  (mmio_addr),
      .mmio_wdata (mmio_wdata),
      .mmio_rdata (mmio_rdata),
      .mmio_ready (mmio_ready),
      .uart_txd   (uart_txd),
      .uart_irq   (uart_irq)
   );

   // Line monitor: one txd/irq sample per clock, taken on the falling edge.
   bit         cap_on = 1'b0;
   logic       txd_log[$];
   logic       irq_log[$];
   logic [7:0] tx_bytes[$];
   logic [0:0] exp_q[$];

   always @(negedge clk) begin
      if (cap_on) begin
         txd_log.push_back(uart_txd);
         irq_log.push_back(uart_irq);
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mmio_req = 1'b0;
      cap_on   = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cycles(1);
   endtask

   task automatic mmio(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata);
      int waited = 0;
      @(posedge clk);
      #1;
      mmio_req   = 1'b1;
      mmio_we    = we;
      mmio_addr  = addr;
      mmio_wdata = wdata;
      do begin
         @(posedge clk);
         #1;
         waited++;
      end while (!mmio_ready && waited < 20);
      check("ready_latency", waited, 1);
      rdata    = mmio_rdata;
      mmio_req = 1'b0;
      @(posedge clk);
      #1;
      check("ready_single_pulse", {31'b0, mmio_ready}, 32'h0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      mmio(1'b1, addr, wdata, dummy);
   endtask

   task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] got;
      mmio(1'b0, addr, 32'h0, got);
      check(name, got, exp);
   endtask

   task automatic start_capture();
      txd_log.delete();
      irq_log.delete();
      cap_on = 1'b1;
   endtask

   task automatic add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic chk, input logic [31:0] exp, input string name);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.chk = chk; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   // Reference waveform: each byte is start(0), 8 data bits LSB first, stop(1); every bit lasts div+1 clocks.
   task automatic check_frames(input string name, input int div, input int max_lead,
                               input int tail, output int k);
      int bad = 0;
      int first_bad = -1;
      logic v;
      k = -1;
      exp_q.delete();
      foreach (tx_bytes[b]) begin
         for (int bi = 0; bi < 10; bi++) begin
            if (bi == 0) v = 1'b0;
            else if (bi == 9) v = 1'b1;
            else v = tx_bytes[b][bi-1];
            repeat (div + 1) exp_q.push_back(v);
         end
      end
      repeat (tail) exp_q.push_back(1'b1);
      for (int i = 0; i < txd_log.size(); i++) begin
         if (txd_log[i] == 1'b0) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k < 0 || k > max_lead) begin
         failures++;
         $display("FAIL %s_start: first start bit at sample %0d, required within %0d", name, k, max_lead);
      end else begin
         checks++;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (k + i >= txd_log.size() || txd_log[k+i] !== exp_q[i][0]) begin
               bad++;
               if (first_bad < 0) first_bad = i;
            end
         end
         if (bad != 0) begin
            failures++;
            $display("FAIL %s_wave: %0d of %0d samples differ, first at offset %0d (required %0b)",
                     name, bad, exp_q.size(), first_bad, exp_q[first_bad][0]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int div;
      int n;
      int irq_bad;
      logic [31:0] got;

      // Reset state
      do_reset();
      check("reset_txd", {31'b0, uart_txd}, 32'h1);
      check("reset_ready", {31'b0, mmio_ready}, 32'h0);
      check("reset_irq", {31'b0, uart_irq}, 32'h0);
      check("reset_rdata", mmio_rdata, 32'h0);
      rd_check("reset_status", A_STATUS, 32'h2);
      rd_check("reset_ctrl", A_CTRL, 32'h0);
      rd_check("reset_bauddiv", A_BAUDDIV, 32'd433);

      // Register map, overflow and decode vectors (transmitter disabled)
      add_vec(1, A_CTRL,    32'h0,         0, 32'h0, "ctrl_off");
      add_vec(1, A_TXDATA,  32'h11,        0, 32'h0, "push_11");
      add_vec(1, A_TXDATA,  32'h12,        0, 32'h0, "push_12");
      add_vec(1, A_TXDATA,  32'h13,        0, 32'h0, "push_13");
      add_vec(1, A_TXDATA,  32'h14,        0, 32'h0, "push_14");
      add_vec(1, A_TXDATA,  32'h15,        0, 32'h0, "push_15");
      add_vec(0, A_STATUS,  32'h0,         1, 32'h9, "status_full_ovf");
      add_vec(1, A_STATUS,  32'h8,         0, 32'h0, "clear_ovf");
      add_vec(0, A_STATUS,  32'h0,         1, 32'h1, "status_full");
      add_vec(0, 32'h14,    32'h0,         1, 32'h1, "status_alias");
      add_vec(0, A_TXDATA,  32'h0,         1, 32'h0, "txdata_read");
      add_vec(1, A_BAUDDIV, 32'hFFFF_0007, 0, 32'h0, "bauddiv_wr");
      add_vec(0, A_BAUDDIV, 32'h0,         1, 32'h7, "bauddiv_rd");
      add_vec(1, A_CTRL,    32'hFFFF_FFFE, 0, 32'h0, "ctrl_wr");
      add_vec(0, A_CTRL,    32'h0,         1, 32'h2, "ctrl_rd");
      add_vec(1, A_TXDATA,  32'h16,        0, 32'h0, "push_16");
      add_vec(1, A_STATUS,  32'h7,         0, 32'h0, "status_no_clear");
      add_vec(0, A_STATUS,  32'h0,         1, 32'h9, "status_ovf_kept");
      for (int i = 0; i < vecs.size(); i++) begin
         mmio(vecs[i].we, vecs[i].addr, vecs[i].wdata, got);
         if (vecs[i].chk) check(vecs[i].name, got, vecs[i].exp);
      end
      check("irq_full_fifo", {31'b0, uart_irq}, 32'h0);

      // Single frame 0xA5 at 4 clocks per bit
      do_reset();
      wr(A_BAUDDIV, 32'd3);
      wr(A_TXDATA, 32'hA5);
      tx_bytes = '{8'hA5};
      start_capture();
      wr(A_CTRL, 32'h1);
      wait_cycles(50);
      cap_on = 1'b0;
      check_frames("frame_a5", 3, 4, 2, k);

      // Back-to-back frames at 1 clock per bit, irq only after the second stop bit
      do_reset();
      wr(A_BAUDDIV, 32'd0);
      wr(A_TXDATA, 32'h00);
      wr(A_TXDATA, 32'hFF);
      tx_bytes = '{8'h00, 8'hFF};
      start_capture();
      wr(A_CTRL, 32'h3);
      wait_cycles(30);
      cap_on = 1'b0;
      check_frames("b2b", 0, 4, 2, k);
      if (k >= 0 && k + 22 < irq_log.size()) begin
         irq_bad = 0;
         for (int i = 0; i <= k + 19; i++) if (irq_log[i] !== 1'b0) irq_bad++;
         check("irq_low_during_frames", irq_bad, 0);
         check("irq_after_drain", {31'b0, irq_log[k+21]}, 32'h1);
      end else begin
         checks++;
         failures++;
         $display("FAIL irq_window: start %0d, log length %0d", k, irq_log.size());
      end
      rd_check("b2b_status", A_STATUS, 32'h2);

      // Enable cleared mid-DATA: frame completes, second byte retained, resumes at once
      do_reset();
      wr(A_BAUDDIV, 32'd3);
      wr(A_TXDATA, 32'h3C);
      wr(A_TXDATA, 32'hC3);
      tx_bytes = '{8'h3C};
      start_capture();
      wr(A_CTRL, 32'h1);
      wait_cycles(12);
      wr(A_CTRL, 32'h0);
      wait_cycles(60);
      cap_on = 1'b0;
      check_frames("disable_mid", 3, 4, 20, k);
      rd_check("disable_status", A_STATUS, 32'h0);
      tx_bytes = '{8'hC3};
      start_capture();
      wr(A_CTRL, 32'h1);
      check("restart_latency", {31'b0, uart_txd}, 32'h0);
      wait_cycles(50);
      cap_on = 1'b0;
      check_frames("resume", 3, 4, 2, k);

      // Asynchronous reset mid-DATA during a ready pulse
      do_reset();
      wr(A_BAUDDIV, 32'd3);
      wr(A_TXDATA, 32'h00);
      wr(A_CTRL, 32'h3);
      wait_cycles(14);
      mmio_req  = 1'b1;
      mmio_we   = 1'b0;
      mmio_addr = A_STATUS;
      @(posedge clk);
      #2;
      check("pre_reset_ready", {31'b0, mmio_ready}, 32'h1);
      check("pre_reset_txd", {31'b0, uart_txd}, 32'h0);
      rst_n    = 1'b0;
      mmio_req = 1'b0;
      #1;
      check("async_rst_txd", {31'b0, uart_txd}, 32'h1);
      check("async_rst_ready", {31'b0, mmio_ready}, 32'h0);
      check("async_rst_irq", {31'b0, uart_irq}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rd_check("post_rst_status", A_STATUS, 32'h2);
      rd_check("post_rst_bauddiv", A_BAUDDIV, 32'd433);
      check("post_rst_txd", {31'b0, uart_txd}, 32'h1);

      // Randomized frame bursts against the waveform model
      for (int it = 0; it < 6; it++) begin
         do_reset();
         div = $urandom_range(0, 3);
         n   = $urandom_range(1, 4);
         wr(A_BAUDDIV, div);
         tx_bytes.delete();
         for (int j = 0; j < n; j++) begin
            tx_bytes.push_back(8'($urandom_range(0, 255)));
            wr(A_TXDATA, {24'b0, tx_bytes[j]});
         end
         start_capture();
         wr(A_CTRL, 32'h1);
         wait_cycles(10 * (div + 1) * n + 12);
         cap_on = 1'b0;
         check_frames($sformatf("rand%0d", it), div, 4, 2, k);
         rd_check($sformatf("rand%0d_status", it), A_STATUS, 32'h2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
